// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced active-high button level into
// single-cycle press / release / auto-repeat events plus a held-level flag.
// All outputs are registered; event latency from the input change is one cycle.
module button_event_gen #(
  parameter int unsigned HOLD_CYCLES   = 12500000,
  parameter int unsigned REPEAT_CYCLES = 2500000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Repeat,
  output logic o_Fire,
  output logic o_Held
);

  localparam int unsigned MAX_CYCLES =
    (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    REPEAT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic             fire_q, fire_d;
  logic             held_q, held_d;

  // Next-state and next-output logic; release is checked before any
  // threshold so a simultaneous release suppresses the repeat.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    held_d    = held_q;

    case (state_q)
      WAIT_LOW: begin
        // A button already held when reset ends must be seen low first.
        if (!i_Switch) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (i_Switch) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end

      PRESSED: begin
        if (!i_Switch) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          held_d    = 1'b0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d  = REPEAT;
          cnt_d    = '0;
          repeat_d = 1'b1;
          held_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      REPEAT: begin
        if (!i_Switch) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          held_d    = 1'b0;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = WAIT_LOW;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase

    fire_d = press_d | repeat_d;
  end

  // State, counter and registered outputs; reset drops everything without
  // issuing a release.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= WAIT_LOW;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      fire_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      fire_q    <= fire_d;
      held_q    <= held_d;
    end
  end

  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Repeat  = repeat_q;
  assign o_Fire    = fire_q;
  assign o_Held    = held_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Testbench for button_event_gen: directed scenarios followed by random
// button activity, each cycle compared against a timing-based reference.
module tb_button_event_gen;

  localparam int unsigned H = 10;
  localparam int unsigned R = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw  = 1'b0;
  logic press, rel, rpt, fire, held;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference state: armed = button seen low since reset; holding = a press
  // is in progress that began at edge index e0.
  int  cyc     = 0;
  int  e0      = 0;
  bit  armed   = 1'b0;
  bit  holding = 1'b0;
  bit  e_press = 1'b0;
  bit  e_rel   = 1'b0;
  bit  e_rep   = 1'b0;
  bit  e_held  = 1'b0;

  button_event_gen #(
    .HOLD_CYCLES  (H),
    .REPEAT_CYCLES(R)
  ) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Switch (sw),
    .o_Press  (press),
    .o_Release(rel),
    .o_Repeat (rpt),
    .o_Fire   (fire),
    .o_Held   (held)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected outputs after an edge that sampled (s, r), from the event rules:
  // repeats at press edge + H + k*R, held from press edge + H until release.
  task automatic model_edge(input bit s, input bit r);
    int n;
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_rep   = 1'b0;
    if (r) begin
      armed   = 1'b0;
      holding = 1'b0;
      e_held  = 1'b0;
    end else if (!armed) begin
      if (!s) armed = 1'b1;
    end else if (!holding) begin
      if (s) begin
        holding = 1'b1;
        e0      = cyc;
        e_press = 1'b1;
      end
    end else if (!s) begin
      holding = 1'b0;
      e_rel   = 1'b1;
      e_held  = 1'b0;
    end else begin
      n      = cyc - e0;
      e_held = (n >= int'(H));
      e_rep  = (n >= int'(H)) && (((n - int'(H)) % int'(R)) == 0);
    end
  endtask

  task automatic step(input bit s, input bit r);
    sw  = s;
    rst = r;
    @(posedge clk);
    model_edge(s, r);
    #1;
    check_eq("press",   press, e_press);
    check_eq("release", rel,   e_rel);
    check_eq("repeat",  rpt,   e_rep);
    check_eq("fire",    fire,  e_press | e_rep);
    check_eq("held",    held,  e_held);
    cyc++;
  endtask

  task automatic run(input bit s, input bit r, input int n);
    for (int i = 0; i < n; i++) step(s, r);
  endtask

  initial begin
    // Reset with button released, then arm.
    run(0, 1, 3);
    run(0, 0, 2);
    // Short 3-cycle press.
    run(1, 0, 3);
    run(0, 0, 3);
    // Long hold: repeats at +10, +14, +18, release at +20.
    run(1, 0, 20);
    run(0, 0, 3);
    // Release exactly at the hold threshold.
    run(1, 0, 10);
    run(0, 0, 3);
    // Button held through reset: no events until seen low, then a re-press.
    run(1, 1, 3);
    run(1, 0, 5);
    run(0, 0, 2);
    run(1, 0, 3);
    run(0, 0, 2);
    // Reset mid-hold, button still high afterwards.
    run(1, 0, 12);
    run(1, 1, 1);
    run(1, 0, 4);
    run(0, 0, 2);
    run(1, 0, 2);
    run(0, 0, 2);
    // Back-to-back single-cycle presses.
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      step(0, 0);
    end
    // Re-press immediately after a release edge.
    run(1, 0, 2);
    step(0, 0);
    run(1, 0, 3);
    run(0, 0, 2);
    // Random button activity with occasional resets.
    for (int seg = 0; seg < 150; seg++) begin
      bit lvl;
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        run(lvl, 1, int'($urandom_range(1, 3)));
      end else begin
        run(lvl, 0, int'($urandom_range(1, 25)));
      end
    end
    // Exclusivity of pulses over a final stretch.
    for (int i = 0; i < 30; i++) begin
      step(1'(i < 22), 0);
      check_eq("press_rep_excl", press & rpt, 1'b0);
      check_eq("rel_excl", rel & (press | rpt), 1'b0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
